avalon_pio_bidir: RTL and testbench

AVALON_PIO_BIDIR -- requirements
Module: avalon_pio_bidir

---
 rtl/pio_pkg.sv | 30 +++
 rtl/pio_sync.sv | 32 +++
 rtl/avalon_pio_bidir.sv | 135 +++++++++++++
 tb/tb_avalon_pio_bidir.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// pio_pkg: constants shared by the bidirectional PIO slave.
//   - Avalon-MM word addresses of the register map (ADDR_DATA..ADDR_OUTCLR)
//   - EDGE_MODE encodings for the edge-capture logic
//   - edge_hit(): per-bit edge detector used by the capture register
package pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Compare the current synchronized level with its one-cycle-old copy.
    // Any unrecognised mode behaves as rising-edge detection.
    function automatic logic [31:0] edge_hit(input int mode,
                                             input logic [31:0] cur,
                                             input logic [31:0] prev);
        logic [31:0] hit;
        hit = cur & ~prev;
        if (mode == EDGE_FALL)     hit = ~cur & prev;
        else if (mode == EDGE_ANY) hit = cur ^ prev;
        return hit;
    endfunction

endpackage

// File: rtl/pio_sync.sv
// pio_sync: WIDTH-bit two-flop synchronizer for asynchronous pad inputs.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset, clears both flop ranks
//   d     - asynchronous input bus
//   q     - synchronized output (two clk edges after first sampling)
module pio_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;

    // first rank (metastability catcher) -> second rank (stable output)
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/avalon_pio_bidir.sv
// avalon_pio_bidir: Avalon-MM slave for a bidirectional PIO port with
// output set/clear, direction control, optional edge capture and interrupt.
// Optional feature macro: PIO_EDGE_IRQ_EN. When defined, IRQMASK (addr 2),
// EDGECAP (addr 3) and irq are built; otherwise those addresses read 0,
// ignore writes, irq is tied 0 and no edge/capture flops exist.
// Parameters: WIDTH (1..32), RESET_VALUE (data_out after reset),
//   EDGE_MODE (0 rise, 1 fall, 2 any), OPEN_DRAIN (1 = drive low only).
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   address, chipselect,
//   write_n, writedata         - Avalon-MM write side (write = cs & ~write_n)
//   readdata                   - zero-wait-state read data, upper bits 0
//   pin_in                     - asynchronous pad inputs
//   pin_out, pin_oe            - pad output value and drive enable
//   irq                        - level interrupt, OR of EDGECAP & IRQMASK
module avalon_pio_bidir
    import pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_MODE   = 0,
    parameter bit               OPEN_DRAIN  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic             irq
);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;

    assign wr = chipselect & ~write_n;
    assign wd = writedata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^writedata[31:WIDTH];
        end
    endgenerate

    // pad input -> sync_q (two edges)
    pio_sync #(.WIDTH(WIDTH)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pin_in),
        .q     (sync_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= RESET_VALUE;
            dir      <= '0;
        end else if (wr) begin
            case (address)
                ADDR_DATA:   data_out <= wd;
                ADDR_DIR:    dir      <= wd;
                ADDR_OUTSET: data_out <= data_out | wd;
                ADDR_OUTCLR: data_out <= data_out & ~wd;
                default:     ;
            endcase
        end
    end

`ifdef PIO_EDGE_IRQ_EN
    logic [WIDTH-1:0] prev_p2;
    logic [WIDTH-1:0] hit;
    logic [WIDTH-1:0] clr;
    logic [31:0]      hit_full;
    logic             unused_hit;

    assign hit_full   = edge_hit(EDGE_MODE, 32'(sync_q), 32'(prev_p2));
    assign hit        = hit_full[WIDTH-1:0];
    assign unused_hit = ^hit_full;
    assign clr        = (wr && address == ADDR_EDGECAP) ? wd : '0;

    // sync_q -> prev_p2 delay; capture sets one edge after the change is
    // visible on sync_q. Set is OR'd in after the clear so it wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_p2 <= '0;
            irqmask <= '0;
            edgecap <= '0;
        end else begin
            prev_p2 <= sync_q;
            edgecap <= (edgecap & ~clr) | hit;
            if (wr && address == ADDR_IRQMASK)
                irqmask <= wd;
        end
    end

    assign irq = (|(edgecap & irqmask)) & ~reset;
`else
    assign irqmask = '0;
    assign edgecap = '0;
    assign irq     = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = sync_q;
            ADDR_DIR:     readdata[WIDTH-1:0] = dir;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap;
            default:      readdata = '0;
        endcase
    end

    // Outputs are forced undriven while reset is held so pads never glitch
    // high during the reset window.
    generate
        if (OPEN_DRAIN) begin : g_od
            assign pin_out = '0;
            assign pin_oe  = reset ? '0 : (dir & ~data_out);
        end else begin : g_pp
            assign pin_out = data_out;
            assign pin_oe  = reset ? '0 : dir;
        end
    endgenerate

endmodule

// File: tb/tb_avalon_pio_bidir.sv
module tb_avalon_pio_bidir;
    import pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  pin_in;

    logic [31:0] rd1, rd2;
    logic [7:0]  po1, po2, oe1, oe2;
    logic        irq1, irq2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // push-pull, reset value 0, rising-edge capture
    avalon_pio_bidir #(.WIDTH(8)) dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1),
        .pin_in(pin_in), .pin_out(po1), .pin_oe(oe1), .irq(irq1)
    );

    // open-drain, reset value 0x3C, falling-edge capture
    avalon_pio_bidir #(.WIDTH(8), .RESET_VALUE(8'h3C), .EDGE_MODE(EDGE_FALL),
                       .OPEN_DRAIN(1'b1)) dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd2),
        .pin_in(pin_in), .pin_out(po2), .pin_oe(oe2), .irq(irq2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
    endtask

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; pin_in = '0;
        step(2);
        chk("rst_oe1", 32'(oe1), 32'h00);
        chk("rst_oe2", 32'(oe2), 32'h00);
        chk("rst_irq1", 32'(irq1), 32'h0);
        reset = 1'b0;
        step(1);
        chk("rst_po1", 32'(po1), 32'h00);
        rd(ADDR_DIR);
        chk("rst_dir", rd1, 32'h0);
        chipselect = 1'b0;

        // data and direction
        wr(ADDR_DATA, 32'hFFFF_FFA5);
        chk("data_po1", 32'(po1), 32'hA5);
        wr(ADDR_DIR, 32'h0000_00FF);
        chk("dir_oe1", 32'(oe1), 32'hFF);
        chk("od_oe2", 32'(oe2), 32'h5A);
        chk("od_po2", 32'(po2), 32'h00);
        rd(ADDR_DIR);
        chk("dir_rd", rd1, 32'h0000_00FF);
        chipselect = 1'b0;

        // set / clear
        wr(ADDR_OUTSET, 32'h0A);
        chk("outset", 32'(po1), 32'hAF);
        wr(ADDR_OUTCLR, 32'h81);
        chk("outclr", 32'(po1), 32'h2E);
        wr(ADDR_DATA, 32'h0F);
        chk("od_oe2_0f", 32'(oe2), 32'hF0);
        chk("od_po2_0f", 32'(po2), 32'h00);

        // unmapped / write-only reads
        wr(3'd6, 32'hFF);
        chk("unmap_po1", 32'(po1), 32'h0F);
        rd(3'd6);
        chk("unmap_rd", rd1, 32'h0);
        rd(ADDR_OUTSET);
        chk("outset_rd", rd1, 32'h0);
        chipselect = 1'b0;

`ifdef PIO_EDGE_IRQ_EN
        wr(ADDR_IRQMASK, 32'h01);
        wr(ADDR_EDGECAP, 32'hFF);
        rd(ADDR_IRQMASK);
        chk("mask_rd", rd1, 32'h01);
        chipselect = 1'b0;
`else
        wr(ADDR_IRQMASK, 32'hFF);
        wr(ADDR_EDGECAP, 32'hFF);
        rd(ADDR_IRQMASK);
        chk("mask_rd_off", rd1, 32'h0);
        chipselect = 1'b0;
`endif

        // synchronizer latency and edge capture
        pin_in = 8'h01;
        step(1);
        rd(ADDR_DATA);
        chk("sync_1edge", rd1, 32'h00);
        chipselect = 1'b0;
        step(1);
        rd(ADDR_DATA);
        chk("sync_2edge", rd1, 32'h01);
`ifdef PIO_EDGE_IRQ_EN
        rd(ADDR_EDGECAP);
        chk("cap_2edge", rd1, 32'h00);
        chk("irq_2edge", 32'(irq1), 32'h0);
        chipselect = 1'b0;
        step(1);
        rd(ADDR_EDGECAP);
        chk("cap_3edge", rd1, 32'h01);
        chk("irq_3edge", 32'(irq1), 32'h1);
        chk("cap2_rise", rd2, 32'h00);
        chk("irq2_rise", 32'(irq2), 32'h0);
        chipselect = 1'b0;
        wr(ADDR_EDGECAP, 32'h01);
        chk("irq_clr", 32'(irq1), 32'h0);

        // capture and clear on the same bit in the same cycle
        pin_in = 8'h03;
        step(2);
        wr(ADDR_EDGECAP, 32'h02);
        rd(ADDR_EDGECAP);
        chk("set_wins", rd1, 32'h02);
        chipselect = 1'b0;

        // falling edges on the falling-mode instance
        pin_in = 8'h00;
        step(3);
        rd(ADDR_EDGECAP);
        chk("cap2_fall", rd2, 32'h03);
        chk("cap1_fall", rd1, 32'h02);
        chk("irq2_fall", 32'(irq2), 32'h1);
        chipselect = 1'b0;
`else
        step(1);
        rd(ADDR_EDGECAP);
        chk("cap_off", rd1, 32'h0);
        chk("irq_off", 32'(irq1), 32'h0);
        chipselect = 1'b0;
        pin_in = 8'h00;
        step(3);
        chk("irq2_off", 32'(irq2), 32'h0);
`endif

        // reset mid-sequence, colliding with a write
        wr(ADDR_DATA, 32'h55);
        chk("pre_rst_po1", 32'(po1), 32'h55);
        pin_in = 8'h01;
        reset = 1'b1;
        address = ADDR_DATA; writedata = 32'hFF; chipselect = 1'b1; write_n = 1'b0;
        step(1);
        chipselect = 1'b0; write_n = 1'b1;
        chk("mid_rst_po1", 32'(po1), 32'h00);
        chk("mid_rst_oe2", 32'(oe2), 32'h00);
        chk("mid_rst_irq1", 32'(irq1), 32'h0);
        chk("mid_rst_irq2", 32'(irq2), 32'h0);
        rd(ADDR_EDGECAP);
        chk("mid_rst_cap", rd1, 32'h0);
        chipselect = 1'b0;
        step(1);
        reset = 1'b0;

        // input held high through reset release
        step(2);
        rd(ADDR_DATA);
        chk("rel_sync", rd1, 32'h01);
`ifdef PIO_EDGE_IRQ_EN
        rd(ADDR_EDGECAP);
        chk("rel_cap_2", rd1, 32'h00);
        chipselect = 1'b0;
        step(1);
        rd(ADDR_EDGECAP);
        chk("rel_cap_3", rd1, 32'h01);
        chk("rel_cap2_3", rd2, 32'h00);
`endif
        chipselect = 1'b0;

        // open-drain instance reloads its reset value
        wr(ADDR_DIR, 32'hFF);
        chk("od_rstval_oe2", 32'(oe2), 32'hC3);
        chk("pp_rstval_po1", 32'(po1), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
